// File: rtl/pzcorebus_pkg.sv
// pzcorebus shared types and command/response classification helpers,
// used by the switches and the outstanding limiter.
package pzcorebus_pkg;

    localparam int ID_WIDTH     = 4;
    localparam int ADDR_WIDTH   = 32;
    localparam int LENGTH_WIDTH = 8;
    localparam int INFO_WIDTH   = 4;
    localparam int DATA_WIDTH   = 32;

    typedef enum logic [1:0] {
        PZCOREBUS_MEMORY_H_PROFILE = 2'd0,
        PZCOREBUS_MEMORY_L_PROFILE = 2'd1,
        PZCOREBUS_CSR_PROFILE      = 2'd2
    } pzcorebus_profile;

    typedef struct packed {
        pzcorebus_profile profile;
    } pzcorebus_config;

    typedef enum logic [2:0] {
        PZCOREBUS_NULL_COMMAND     = 3'd0,
        PZCOREBUS_WRITE            = 3'd1,
        PZCOREBUS_WRITE_NON_POSTED = 3'd2,
        PZCOREBUS_READ             = 3'd3,
        PZCOREBUS_BROADCAST        = 3'd4,
        PZCOREBUS_MESSAGE          = 3'd5
    } pzcorebus_command_type;

    typedef enum logic [1:0] {
        PZCOREBUS_NULL_RESPONSE      = 2'd0,
        PZCOREBUS_RESPONSE           = 2'd1,
        PZCOREBUS_RESPONSE_WITH_DATA = 2'd2
    } pzcorebus_response_type;

    function automatic logic is_non_posted_command(pzcorebus_command_type mcmd);
        case (mcmd)
            PZCOREBUS_READ, PZCOREBUS_WRITE_NON_POSTED: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // CSR responses are always single-beat, so every beat closes its command.
    function automatic logic is_last_response_beat(pzcorebus_config bus_config, logic [1:0] sresp_last);
        if (bus_config.profile == PZCOREBUS_CSR_PROFILE) begin
            return 1'b1;
        end else begin
            return sresp_last[0];
        end
    endfunction

endpackage

// File: rtl/pzcorebus_if.sv
// pzcorebus command/data/response channel bundle with master and slave views.
interface pzcorebus_if;
    import pzcorebus_pkg::*;

    logic                        mcmd_valid;
    logic                        mcmd_accept;
    pzcorebus_command_type       mcmd;
    logic [ID_WIDTH-1:0]         mid;
    logic [ADDR_WIDTH-1:0]       maddr;
    logic [LENGTH_WIDTH-1:0]     mlength;
    logic [INFO_WIDTH-1:0]       minfo;
    logic                        mdata_valid;
    logic                        mdata_accept;
    logic [DATA_WIDTH-1:0]       mdata;
    logic                        mdata_last;
    logic                        sresp_valid;
    logic                        sresp_accept;
    pzcorebus_response_type      sresp;
    logic [ID_WIDTH-1:0]         sid;
    logic [DATA_WIDTH-1:0]       sdata;
    logic [1:0]                  sresp_last;

    modport master (
        output mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        input  mcmd_accept,
        output mdata_valid, mdata, mdata_last,
        input  mdata_accept,
        input  sresp_valid, sresp, sid, sdata, sresp_last,
        output sresp_accept
    );

    modport slave (
        input  mcmd_valid, mcmd, mid, maddr, mlength, minfo,
        output mcmd_accept,
        input  mdata_valid, mdata, mdata_last,
        output mdata_accept,
        output sresp_valid, sresp, sid, sdata, sresp_last,
        input  sresp_accept
    );

endinterface

// File: rtl/pzcorebus_outstanding_counter.sv
// Saturating in-flight counter with runtime limit clamp and full flag.
module pzcorebus_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [COUNT_WIDTH-1:0] i_limit,
    input  logic                   i_inc,
    input  logic                   i_dec,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_busy,
    output logic                   o_full
);

    localparam logic [COUNT_WIDTH-1:0] ZERO  = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] ONE   = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_OUTSTANDING);

    logic [COUNT_WIDTH-1:0] count_r;
    logic [COUNT_WIDTH-1:0] count_next_s;
    logic [COUNT_WIDTH-1:0] eff_limit_s;
    logic                   busy_r;

    // Clamp the runtime limit: zero or out-of-range means the hardware ceiling.
    always_comb begin
        eff_limit_s = MAX_C;
        if ((i_limit == ZERO) || (i_limit > MAX_C)) begin
            eff_limit_s = MAX_C;
        end else begin
            eff_limit_s = i_limit;
        end
    end

    // Next count; simultaneous inc and dec cancel, both ends saturate.
    always_comb begin
        count_next_s = count_r;
        case ({i_inc, i_dec})
            2'b10: begin
                if (count_r < MAX_C) begin
                    count_next_s = count_r + ONE;
                end else begin
                    count_next_s = count_r;
                end
            end
            2'b01: begin
                if (count_r != ZERO) begin
                    count_next_s = count_r - ONE;
                end else begin
                    count_next_s = count_r;
                end
            end
            default: count_next_s = count_r;
        endcase
    end

    // Count and busy registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= ZERO;
            busy_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            busy_r  <= (count_next_s != ZERO);
        end
    end

    // Full looks only at the registered count, so a retiring response frees a slot next cycle.
    assign o_full  = (count_r >= eff_limit_s);
    assign o_count = count_r;
    assign o_busy  = busy_r;

endmodule

// File: rtl/pzcorebus_outstanding_limiter.sv
// Stalls non-posted commands once the in-flight count reaches a runtime limit.
// Optional watchdog enabled by PZCOREBUS_OUTSTANDING_LIMITER_TIMEOUT_EN.
module pzcorebus_outstanding_limiter
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG      = '0,
    parameter int              MAX_OUTSTANDING = 16,
    parameter int              COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1),
    parameter int              TIMEOUT_CYCLES  = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [COUNT_WIDTH-1:0] i_limit,
    output logic [COUNT_WIDTH-1:0] o_outstanding,
    output logic                   o_busy,
    output logic                   o_unexpected_response,
    output logic                   o_timeout,
    pzcorebus_if.slave             slave_if,
    pzcorebus_if.master            master_if
);

    if ((MAX_OUTSTANDING < 1) || (TIMEOUT_CYCLES < 1) ||
        (COUNT_WIDTH < $clog2(MAX_OUTSTANDING + 1))) begin : g_param_check
        $error("pzcorebus_outstanding_limiter: invalid parameters");
    end

    logic np_s;
    logic full_s;
    logic stall_s;
    logic inc_s;
    logic dec_s;
    logic unexpected_r;

    assign np_s    = is_non_posted_command(slave_if.mcmd);
    assign stall_s = np_s && full_s;

    assign master_if.mcmd_valid = slave_if.mcmd_valid && !stall_s;
    assign slave_if.mcmd_accept = master_if.mcmd_accept && !stall_s;
    assign master_if.mcmd       = slave_if.mcmd;
    assign master_if.mid        = slave_if.mid;
    assign master_if.maddr      = slave_if.maddr;
    assign master_if.mlength    = slave_if.mlength;
    assign master_if.minfo      = slave_if.minfo;

    assign master_if.mdata_valid = slave_if.mdata_valid;
    assign slave_if.mdata_accept = master_if.mdata_accept;
    assign master_if.mdata       = slave_if.mdata;
    assign master_if.mdata_last  = slave_if.mdata_last;

    assign slave_if.sresp_valid   = master_if.sresp_valid;
    assign master_if.sresp_accept = slave_if.sresp_accept;
    assign slave_if.sresp         = master_if.sresp;
    assign slave_if.sid           = master_if.sid;
    assign slave_if.sdata         = master_if.sdata;
    assign slave_if.sresp_last    = master_if.sresp_last;

    assign inc_s = slave_if.mcmd_valid && slave_if.mcmd_accept && np_s;
    assign dec_s = slave_if.sresp_valid && slave_if.sresp_accept &&
                   is_last_response_beat(BUS_CONFIG, slave_if.sresp_last);

    pzcorebus_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .COUNT_WIDTH     (COUNT_WIDTH)
    ) u_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_limit (i_limit),
        .i_inc   (inc_s),
        .i_dec   (dec_s),
        .o_count (o_outstanding),
        .o_busy  (o_busy),
        .o_full  (full_s)
    );

    // A final response with nothing in flight is flagged for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            unexpected_r <= 1'b0;
        end else begin
            unexpected_r <= dec_s && !o_busy;
        end
    end

    assign o_unexpected_response = unexpected_r;

`ifdef PZCOREBUS_OUTSTANDING_LIMITER_TIMEOUT_EN
    localparam int                  WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_MAX   = WD_WIDTH'(TIMEOUT_CYCLES);

    logic [WD_WIDTH-1:0] wd_count_r;
    logic [WD_WIDTH-1:0] wd_next_s;
    logic                timeout_r;

    // Watchdog restarts on any retirement or when idle, saturates at the threshold.
    always_comb begin
        wd_next_s = wd_count_r;
        if (!o_busy || dec_s) begin
            wd_next_s = {WD_WIDTH{1'b0}};
        end else if (wd_count_r < WD_MAX) begin
            wd_next_s = wd_count_r + WD_WIDTH'(1);
        end else begin
            wd_next_s = wd_count_r;
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_count_r <= {WD_WIDTH{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            wd_count_r <= wd_next_s;
            timeout_r  <= timeout_r || (wd_next_s == WD_MAX);
        end
    end

    assign o_timeout = timeout_r;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pzcorebus_outstanding_limiter.sv
// Directed bench for pzcorebus_outstanding_limiter (watchdog steps active with
// PZCOREBUS_OUTSTANDING_LIMITER_TIMEOUT_EN).
module tb_pzcorebus_outstanding_limiter;
    import pzcorebus_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [4:0] i_limit;
    logic [4:0] o_outstanding;
    logic       o_busy;
    logic       o_unexpected_response;
    logic       o_timeout;

    int tests = 0;
    int fails = 0;

    pzcorebus_if up_if ();
    pzcorebus_if dn_if ();

    always #5 i_clk = ~i_clk;

    pzcorebus_outstanding_limiter #(
        .MAX_OUTSTANDING (16),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_limit               (i_limit),
        .o_outstanding         (o_outstanding),
        .o_busy                (o_busy),
        .o_unexpected_response (o_unexpected_response),
        .o_timeout             (o_timeout),
        .slave_if              (up_if.slave),
        .master_if             (dn_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n            = 1'b0;
        i_limit            = 5'd2;
        up_if.mcmd_valid   = 1'b0;
        up_if.mcmd         = PZCOREBUS_READ;
        up_if.mid          = 4'd0;
        up_if.maddr        = 32'h0;
        up_if.mlength      = 8'd0;
        up_if.minfo        = 4'd0;
        up_if.mdata_valid  = 1'b0;
        up_if.mdata        = 32'h0;
        up_if.mdata_last   = 1'b0;
        up_if.sresp_accept = 1'b1;
        dn_if.mcmd_accept  = 1'b1;
        dn_if.mdata_accept = 1'b1;
        dn_if.sresp_valid  = 1'b0;
        dn_if.sresp        = PZCOREBUS_RESPONSE_WITH_DATA;
        dn_if.sid          = 4'd0;
        dn_if.sdata        = 32'h0;
        dn_if.sresp_last   = 2'b00;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_outstanding", 32'(o_outstanding), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_unexpected", 32'(o_unexpected_response), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Limit 2: three back-to-back READs, third stalls.
        up_if.mcmd_valid = 1'b1; up_if.maddr = 32'h1000; up_if.mid = 4'd1; #1;
        chk("rd1_valid", 32'(dn_if.mcmd_valid), 32'd1);
        chk("rd1_accept", 32'(up_if.mcmd_accept), 32'd1);
        chk("rd1_maddr", dn_if.maddr, 32'h1000);
        chk("rd1_mid", 32'(dn_if.mid), 32'd1);
        tick();
        up_if.maddr = 32'h1004; up_if.mid = 4'd2; #1;
        chk("rd2_valid", 32'(dn_if.mcmd_valid), 32'd1);
        chk("rd2_count", 32'(o_outstanding), 32'd1);
        tick();
        up_if.maddr = 32'h1008; up_if.mid = 4'd3; #1;
        chk("rd3_stall_valid", 32'(dn_if.mcmd_valid), 32'd0);
        chk("rd3_stall_accept", 32'(up_if.mcmd_accept), 32'd0);
        chk("rd3_count", 32'(o_outstanding), 32'd2);
        chk("rd3_busy", 32'(o_busy), 32'd1);
        tick();

        // Final response in cycle N: stalled READ still blocked in N, goes in N+1.
        dn_if.sresp_valid = 1'b1; dn_if.sresp_last = 2'b01; dn_if.sdata = 32'hCAFE0001; dn_if.sid = 4'd1; #1;
        chk("resp_n_valid_blocked", 32'(dn_if.mcmd_valid), 32'd0);
        chk("resp_pass_valid", 32'(up_if.sresp_valid), 32'd1);
        chk("resp_pass_sdata", up_if.sdata, 32'hCAFE0001);
        chk("resp_pass_accept", 32'(dn_if.sresp_accept), 32'd1);
        tick();
        dn_if.sresp_valid = 1'b0; #1;
        chk("resp_n1_count", 32'(o_outstanding), 32'd1);
        chk("resp_n1_valid", 32'(dn_if.mcmd_valid), 32'd1);
        chk("resp_n1_accept", 32'(up_if.mcmd_accept), 32'd1);
        tick();
        up_if.mcmd_valid = 1'b0; #1;
        chk("after_unstall_count", 32'(o_outstanding), 32'd2);

        // Non-final beat does not retire; final beat does.
        dn_if.sresp_valid = 1'b1; dn_if.sresp_last = 2'b00;
        tick();
        dn_if.sresp_valid = 1'b0; #1;
        chk("nonfinal_count", 32'(o_outstanding), 32'd2);
        dn_if.sresp_valid = 1'b1; dn_if.sresp_last = 2'b01;
        tick();
        dn_if.sresp_valid = 1'b0; #1;
        chk("final_count", 32'(o_outstanding), 32'd1);

        // Limit 1 with 1 outstanding: posted writes flow, READ stalls.
        i_limit = 5'd1;
        up_if.mcmd_valid = 1'b1; up_if.mcmd = PZCOREBUS_WRITE;
        up_if.mdata_valid = 1'b1; up_if.mdata_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_if.maddr = 32'h2000 + 32'(i * 4); up_if.mdata = 32'hD000 + 32'(i); #1;
            chk("posted_valid", 32'(dn_if.mcmd_valid), 32'd1);
            chk("posted_accept", 32'(up_if.mcmd_accept), 32'd1);
            chk("posted_mdata", dn_if.mdata, 32'hD000 + 32'(i));
            tick();
        end
        up_if.mdata_valid = 1'b0;
        chk("posted_count", 32'(o_outstanding), 32'd1);
        up_if.mcmd = PZCOREBUS_READ; #1;
        chk("full_read_stall", 32'(dn_if.mcmd_valid), 32'd0);
        up_if.mcmd_valid = 1'b0;

        // Simultaneous np handshake and final response: count unchanged.
        i_limit = 5'd2;
        up_if.mcmd_valid = 1'b1; up_if.mcmd = PZCOREBUS_WRITE_NON_POSTED;
        dn_if.sresp_valid = 1'b1; dn_if.sresp_last = 2'b01; #1;
        chk("both_valid", 32'(dn_if.mcmd_valid), 32'd1);
        tick();
        up_if.mcmd_valid = 1'b0; dn_if.sresp_valid = 1'b0; #1;
        chk("both_count", 32'(o_outstanding), 32'd1);

        // Drain to zero, then an unexpected final response.
        dn_if.sresp_valid = 1'b1;
        tick();
        dn_if.sresp_valid = 1'b0; #1;
        chk("drain_count", 32'(o_outstanding), 32'd0);
        chk("drain_busy", 32'(o_busy), 32'd0);
        chk("drain_no_unexpected", 32'(o_unexpected_response), 32'd0);
        dn_if.sresp_valid = 1'b1;
        tick();
        dn_if.sresp_valid = 1'b0; #1;
        chk("unexp_pulse", 32'(o_unexpected_response), 32'd1);
        chk("unexp_count", 32'(o_outstanding), 32'd0);
        tick();
        chk("unexp_pulse_end", 32'(o_unexpected_response), 32'd0);

        // Reset mid-operation clears the count at once; late response is unexpected.
        up_if.mcmd_valid = 1'b1; up_if.mcmd = PZCOREBUS_READ;
        tick();
        up_if.mcmd_valid = 1'b0; #1;
        chk("pre_rst_count", 32'(o_outstanding), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(o_outstanding), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        #1 i_rst_n = 1'b1;
        tick();
        dn_if.sresp_valid = 1'b1;
        tick();
        dn_if.sresp_valid = 1'b0; #1;
        chk("post_rst_unexp", 32'(o_unexpected_response), 32'd1);
        chk("post_rst_count", 32'(o_outstanding), 32'd0);

`ifdef PZCOREBUS_OUTSTANDING_LIMITER_TIMEOUT_EN
        // One READ with no response: timeout 8 cycles after issue, sticky until reset.
        up_if.mcmd_valid = 1'b1;
        tick();
        up_if.mcmd_valid = 1'b0; #1;
        chk("wd_count", 32'(o_outstanding), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("wd_not_yet", 32'(o_timeout), 32'd0);
        end
        tick();
        chk("wd_timeout_set", 32'(o_timeout), 32'd1);
        dn_if.sresp_valid = 1'b1;
        tick();
        dn_if.sresp_valid = 1'b0; #1;
        chk("wd_sticky", 32'(o_timeout), 32'd1);
        chk("wd_late_count", 32'(o_outstanding), 32'd0);
        i_rst_n = 1'b0; #1;
        chk("wd_rst_clear", 32'(o_timeout), 32'd0);
        i_rst_n = 1'b1;
`else
        up_if.mcmd_valid = 1'b1;
        tick();
        up_if.mcmd_valid = 1'b0;
        repeat (12) tick();
        chk("timeout_tied_low", 32'(o_timeout), 32'd0);
        chk("idle_np_count", 32'(o_outstanding), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pzcorebus_outstanding_limiter.md
# pzcorebus_outstanding_limiter

Request-flow regulator that sits directly upstream of `pzcorebus_1_to_m_switch`, between the requesting agent and the switch's slave port. It counts non-posted commands in flight and stalls new ones once a runtime limit is reached. Responses returning from the switch retire that count. Every other field passes through unchanged with zero latency.

## Interface
- `BUS_CONFIG`, default `'0`: pzcorebus configuration shared with the downstream switch.
- `MAX_OUTSTANDING`, default 16: hardware ceiling on in-flight non-posted commands; must be ≥1.
- `COUNT_WIDTH`, default `$clog2(MAX_OUTSTANDING+1)`: width of the counter and of the limit.
- `TIMEOUT_CYCLES`, default 1024: watchdog threshold, used only when the timeout macro is defined.
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_limit`, input, COUNT_WIDTH: runtime limit.
  - 0 or any value >MAX_OUTSTANDING is treated as MAX_OUTSTANDING.
  - Sampled every cycle.
- `o_outstanding`, output, COUNT_WIDTH: current in-flight count (registered).
- `o_busy`, output, 1: high when `o_outstanding != 0`.
- `o_unexpected_response`, output, 1: one-cycle pulse when a final response beat is accepted while the count is 0.
- `o_timeout`, output, 1: sticky watchdog flag; tied 0 when the macro is absent.
- `slave_if`, `pzcorebus_if.slave`: upstream agent.
- `master_if`, `pzcorebus_if.master`: toward the switch.

## Operation
- Non-posted command: `mcmd` is READ or WRITE_NON_POSTED, decided with the package helper. All other commands (posted write, broadcast, message) bypass the limiter.
- Command gate, with `full = (o_outstanding >= effective_limit)`:
  - `master.mcmd_valid = slave.mcmd_valid && !(np && full)`.
  - `slave.mcmd_accept = master.mcmd_accept && !(np && full)`.
  - `mid`, `maddr`, `mlength` and `minfo` pass through wired.
- Data channel and response channel: pure pass-through, both directions, no gating.
- Increment: on an np command handshake.
- Decrement: on a response handshake whose beat is the final beat of a command (`sresp_last` bit 0 set).
- Both events in the same cycle: count unchanged.
- Decrement while the count is 0: count stays 0 and `o_unexpected_response` pulses.
- Increment at MAX_OUTSTANDING cannot occur, because the gate blocks it.
- The limit is lowered below the current count: no commands are dropped. New np commands stall until the count falls below the new limit.
- Posted commands are never stalled, even when `full` is high.

## Timing
- Command, data and response paths: 0-cycle combinational pass-through.
- Counter: updates on the clock edge after the handshake.
- `full` is computed from the registered count only.
  - A final response in cycle N unblocks a stalled np command in cycle N+1, not in cycle N.
  - At the limit this costs one bubble cycle; the bubble is intentional.
- Reset values:
  - `o_outstanding`=0, `o_busy`=0, `o_unexpected_response`=0, `o_timeout`=0, watchdog counter=0.
- Reset mid-operation: the count clears immediately. Responses that arrive afterwards for pre-reset commands raise `o_unexpected_response`; the count stays 0.
- `valid`/`accept` rules of pzcorebus hold: a stalled np command keeps `master.mcmd_valid` low. The upstream agent must still hold its payload stable.

## Configuration
- Macro: `PZCOREBUS_OUTSTANDING_LIMITER_TIMEOUT_EN`.
- Defined:
  - A watchdog counter increments each cycle while `o_outstanding != 0` and no final response is accepted.
  - It resets to 0 on any final response or when the count is 0.
  - When it reaches TIMEOUT_CYCLES, `o_timeout` sets. `o_timeout` clears only by reset.
  - The watchdog counter saturates at TIMEOUT_CYCLES.
- Undefined: no watchdog logic is generated and `o_timeout` is constant 0.

## Structure
- `pzcorebus_pkg` gains `is_non_posted_command(pzcorebus_command_type)` and `is_last_response_beat(...)` helper functions, shared with the switches.
- Sub-module `pzcorebus_outstanding_counter` holds the up/down saturating counter, the limit clamp and `full` generation. The top holds the gating, the unexpected-response pulse and the watchdog.

## Test plan
- Limit 2, send 3 back-to-back READs, no responses: 2 pass, the 3rd stalls, `o_outstanding`=2.
- From the previous state, one final response in cycle N: `o_outstanding`=1 at N+1 and the stalled READ is accepted at N+1, not N.
- Limit 1 with 1 outstanding: 4 posted WRITEs pass with no stall and the count stays 1.
- Count 1, np command handshake and final response in the same cycle: count stays 1.
- Final response with count 0: `o_unexpected_response` pulses for 1 cycle and the count stays 0.
- Macro on, TIMEOUT_CYCLES=8, 1 READ with no response: `o_timeout` sets 8 cycles after issue and stays high after a late response; reset clears it.
